// File: rtl/apb_arbiter.sv
// apb_arbiter: three-requester round-robin arbiter driving a single APB master
// port. Each transfer runs IDLE -> SETUP -> ACCESS and returns to IDLE, where
// the owning requester sees a one-cycle done pulse with err/rdata.
module apb_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [2:0]            req,
  input  logic [2:0]            req_write,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            grant,
  output logic [2:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] TO_L = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [2:0]          grant_q, grant_d;
  logic [2:0]          done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

  logic [1:0]          win;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;
  logic [7:0]          wait_inc;

  // Round-robin pick: scan starts just after the last granted requester.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    pick = 2'd0;
    case (last)
      2'd0:    pick = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd1:    pick = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: pick = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
    return pick;
  endfunction

  assign win      = rr_pick(req, last_q);
  assign wait_inc = wait_cnt_q + 8'd1;

  // Mux out the winning requester's address, data and direction.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (win == 2'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  // Next-state and registered-output computation for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wait_cnt_d = wait_cnt_q;
    grant_d    = grant_q;
    done_d     = 3'b000;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (|req) begin
          state_d    = SETUP;
          last_d     = win;
          grant_d    = 3'b001 << win;
          paddr_d    = sel_addr;
          pwdata_d   = sel_wdata;
          pwrite_d   = sel_write;
          psel_d     = 1'b1;
          wait_cnt_d = 8'd0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d   = IDLE;
          done_d    = grant_q;
          err_d     = PSLVERR;
          if (!pwrite_q) rdata_d = PRDATA;
          grant_d   = 3'b000;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end else if (wait_inc == TO_L) begin
          // Slave never answered: abort with an error, keep old rdata.
          state_d    = IDLE;
          done_d     = grant_q;
          err_d      = 1'b1;
          grant_d    = 3'b000;
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          wait_cnt_d = wait_inc;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      default: begin
        state_d   = IDLE;
        grant_d   = 3'b000;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      last_q     <= 2'd2;
      wait_cnt_q <= 8'd0;
      grant_q    <= 3'b000;
      done_q     <= 3'b000;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: scoreboard bench for apb_arbiter. Requests are issued in
// batches; the expected per-transfer outcome is queued at issue time and a
// monitor checks it when the DUT presents the APB phases and the done pulse.
module tb_apb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK, PRESET;
  logic [2:0]    req, req_write;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]    grant, done;
  logic [DW-1:0] rdata;
  logic          err, PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .err(err), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic [2:0]    onehot;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
    int            acc;
    bit            chk_gap;
  } exp_t;

  typedef struct {
    int            waits;
    logic          slverr;
    logic [DW-1:0] prdata;
  } plan_t;

  exp_t  sb[$];
  plan_t plan_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Per-requester transaction parameters for the next batch.
  logic          t_write [3];
  logic [AW-1:0] t_addr  [3];
  logic [DW-1:0] t_wdata [3];
  int            t_waits [3];
  logic          t_slverr[3];
  logic [DW-1:0] t_prdata[3];

  // Reference state: last granted requester and current rdata register.
  int            model_last  = 2;
  logic [DW-1:0] model_rdata = '0;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rand_req(input int i);
    int r;
    t_write[i]  = 1'($urandom % 2);
    t_addr[i]   = $urandom;
    t_wdata[i]  = $urandom;
    t_slverr[i] = ($urandom % 4) == 0;
    t_prdata[i] = $urandom;
    r = $urandom % 10;
    if (r < 6)       t_waits[i] = $urandom_range(0, 2);
    else if (r < 8)  t_waits[i] = $urandom_range(3, TO - 1);
    else if (r == 8) t_waits[i] = TO - 1;
    else             t_waits[i] = TO + $urandom_range(0, 2);
  endtask

  // Push expectations for a batch in service order, then raise the requests.
  task automatic push_batch(input logic [2:0] mask);
    exp_t  e;
    plan_t p;
    int    start;
    bit    first;
    bit    tout;
    start = model_last;
    first = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (start + k) % 3;
      if (mask[i]) begin
        tout      = t_waits[i] >= TO;
        e.onehot  = 3'(1 << i);
        e.addr    = t_addr[i];
        e.wr      = t_write[i];
        e.wdata   = t_wdata[i];
        e.err     = tout ? 1'b1 : t_slverr[i];
        if (!tout && !t_write[i]) model_rdata = t_prdata[i];
        e.rdata   = model_rdata;
        e.acc     = tout ? TO : t_waits[i] + 1;
        e.chk_gap = !first;
        sb.push_back(e);
        p.waits  = t_waits[i];
        p.slverr = t_slverr[i];
        p.prdata = t_prdata[i];
        plan_q.push_back(p);
        model_last = i;
        first = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      req_write[i]            = t_write[i];
      req_addr[i*AW +: AW]    = t_addr[i];
      req_wdata[i*DW +: DW]   = t_wdata[i];
    end
    req = mask;
  endtask

  // Requesters drop their request after seeing their done pulse.
  task automatic wait_batch();
    for (int c = 0; c < 500 && req != 3'b000; c++) begin
      @(negedge PCLK);
      req = req & ~done;
    end
    chk("batch_complete", 64'(req), 64'd0);
    req = 3'b000;
  endtask

  task automatic run_batch(input logic [2:0] mask);
    push_batch(mask);
    wait_batch();
  endtask

  task automatic do_reset();
    @(posedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    sb.delete();
    plan_q.delete();
    req = 3'b000;
    model_last  = 2;
    model_rdata = '0;
    repeat (2) @(posedge PCLK);
    #2 PRESET = 1'b0;
  endtask

  // APB slave: wait states, PSLVERR and PRDATA follow the per-transfer plan.
  initial begin
    plan_t cur;
    bit    in_xfer;
    int    scnt;
    in_xfer = 1'b0;
    scnt    = 0;
    cur.waits = 0; cur.slverr = 1'b0; cur.prdata = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE && !PRESET) begin
        if (!in_xfer) begin
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else begin
            cur.waits = 1000; cur.slverr = 1'b0; cur.prdata = '0;
          end
          in_xfer = 1'b1;
          scnt    = 0;
        end else begin
          scnt++;
        end
        PREADY  = (scnt == cur.waits);
        PSLVERR = PREADY ? cur.slverr : 1'($urandom % 2);
        PRDATA  = PREADY ? cur.prdata : $urandom;
      end else begin
        in_xfer = 1'b0;
        PREADY  = 1'($urandom % 2);
        PSLVERR = 1'($urandom % 2);
        PRDATA  = $urandom;
      end
    end
  end

  // Monitor: checks APB phases against the queue head and pops on done.
  initial begin
    exp_t e;
    int   acc_cnt;
    int   last_done;
    acc_cnt   = 0;
    last_done = 0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        acc_cnt = 0;
      end else begin
        if (PSEL && !PENABLE) begin
          if (sb.size() > 0) begin
            chk("setup_grant", 64'(grant), 64'(sb[0].onehot));
            chk("setup_paddr", 64'(PADDR), 64'(sb[0].addr));
          end else chk("setup_expected", 64'd0, 64'd1);
        end
        if (PSEL && PENABLE) begin
          acc_cnt++;
          if (sb.size() > 0) begin
            chk("acc_grant", 64'(grant), 64'(sb[0].onehot));
            chk("acc_paddr", 64'(PADDR), 64'(sb[0].addr));
            chk("acc_pwrite", 64'(PWRITE), 64'(sb[0].wr));
            chk("acc_pwdata", 64'(PWDATA), 64'(sb[0].wdata));
          end else chk("acc_expected", 64'd0, 64'd1);
          chk("acc_no_done", 64'(done), 64'd0);
        end
        if (done != 3'b000) begin
          if (sb.size() == 0) chk("done_expected", 64'(done), 64'd0);
          else begin
            e = sb.pop_front();
            chk("done_onehot", 64'(done), 64'(e.onehot));
            chk("done_err", 64'(err), 64'(e.err));
            chk("done_rdata", 64'(rdata), 64'(e.rdata));
            chk("access_cycles", 64'(acc_cnt), 64'(e.acc));
            chk("done_psel", 64'(PSEL), 64'd0);
            chk("done_grant", 64'(grant), 64'd0);
            if (e.chk_gap) chk("xfer_gap", 64'(cyc - last_done), 64'(e.acc + 2));
          end
          acc_cnt   = 0;
          last_done = cyc;
        end else begin
          chk("err_idle", 64'(err), 64'd0);
        end
      end
    end
  end

  initial begin
    PRESET    = 1'b0;
    req       = 3'b000;
    req_write = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 3; i++) rand_req(i);
    do_reset();

    // Single zero-wait write from requester 0.
    t_write[0] = 1'b1; t_addr[0] = 32'h10; t_wdata[0] = 32'hDEADBEEF;
    t_waits[0] = 0; t_slverr[0] = 1'b0; t_prdata[0] = 32'h0;
    run_batch(3'b001);

    // Read from requester 1 with two wait states.
    t_write[1] = 1'b0; t_addr[1] = 32'h20; t_wdata[1] = 32'h0;
    t_waits[1] = 2; t_slverr[1] = 1'b0; t_prdata[1] = 32'h12345678;
    run_batch(3'b010);

    // Round-robin from reset: 0,1,2 then 0, zero wait states.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_req(i);
      t_waits[i] = 0;
    end
    run_batch(3'b111);
    rand_req(0);
    t_waits[0] = 0;
    run_batch(3'b001);

    // Timeout on requester 2, then requester 0 is served.
    rand_req(2); t_waits[2] = TO + 4;
    rand_req(0); t_waits[0] = 1;
    run_batch(3'b101);

    // Ready on the last allowed cycle completes normally.
    rand_req(1); t_waits[1] = TO - 1; t_write[1] = 1'b0; t_slverr[1] = 1'b0;
    run_batch(3'b010);

    // Slave error on a write.
    rand_req(2); t_write[2] = 1'b1; t_waits[2] = 0; t_slverr[2] = 1'b1;
    run_batch(3'b100);

    // Randomized batches.
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 3; i++) rand_req(i);
      run_batch(3'($urandom_range(1, 7)));
    end

    // Reset in the middle of ACCESS abandons the transfer.
    rand_req(0); t_waits[0] = TO + 3;
    push_batch(3'b001);
    for (int c = 0; c < 20 && !(PSEL && PENABLE); c++) @(negedge PCLK);
    chk("reached_access", 64'(PSEL && PENABLE), 64'd1);
    repeat (2) @(negedge PCLK);
    @(posedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    chk("midrst_psel", 64'(PSEL), 64'd0);
    chk("midrst_penable", 64'(PENABLE), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd0);
    sb.delete();
    plan_q.delete();
    req = 3'b000;
    model_last  = 2;
    model_rdata = '0;
    repeat (2) begin
      @(negedge PCLK);
      chk("midrst_done", 64'(done), 64'd0);
    end
    @(posedge PCLK);
    #2 PRESET = 1'b0;
    @(negedge PCLK);
    chk("postrst_done", 64'(done), 64'd0);
    rand_req(1); t_waits[1] = 0;
    rand_req(2); t_waits[2] = 1;
    run_batch(3'b110);

    repeat (5) @(negedge PCLK);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles with PREADY low before abort (range 2..255).
REQ-004 PCLK  in  1  clock; all state changes on its rising edge.
REQ-005 PRESET  in  1  reset, asynchronous, active-high.
REQ-006 req  in  3  per-requester transfer request; requester i holds req[i] high until done[i].
REQ-007 req_write  in  3  per-requester direction: 1 write, 0 read.
REQ-008 req_addr  in  3*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  in  3*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
REQ-010 grant  out  3  one-hot; high for the owning requester from SETUP through the completing ACCESS cycle.
REQ-011 done  out  3  one-cycle pulse to the owning requester when its transfer ends.
REQ-012 rdata  out  DATA_W  read data; valid in the done cycle of a read.
REQ-013 err  out  1  valid with done: 1 on PSLVERR or timeout.
REQ-014 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-015 PADDR  out  ADDR_W, PWDATA  out  DATA_W  APB address/write data.
REQ-016 PRDATA  in  DATA_W, PREADY  in  1, PSLVERR  in  1  APB slave response.

Function
REQ-017 FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-018 IDLE: PSEL=0, PENABLE=0; if any req bit high, select winner, register grant/PADDR/PWRITE/PWDATA from winner's inputs, next state SETUP.
REQ-019 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod 3; last_granted updates on every grant.
REQ-020 SETUP: PSEL=1, PENABLE=0, unconditionally next state ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL stay stable from SETUP until transfer end.
REQ-022 ACCESS with PREADY=1: pulse done[grant] next cycle, err<=PSLVERR, rdata<=PRDATA if read (rdata unchanged on write), next state IDLE, grant cleared.
REQ-023 ACCESS with PREADY=0: increment wait counter; when counter reaches TIMEOUT, abort: done pulse, err=1, rdata unchanged, next state IDLE.
REQ-024 Wait counter SHALL clear on entry to SETUP; the abort fires on the TIMEOUT-th consecutive PREADY-low ACCESS cycle.
REQ-025 req SHALL be sampled only in IDLE; req changes during SETUP/ACCESS SHALL not affect the current transfer.
REQ-026 Every transfer SHALL pass through IDLE (one idle cycle between transfers); max throughput one transfer per 3 cycles with zero wait states.
REQ-027 done and err SHALL be low in all cycles other than the done cycle.
REQ-028 Simultaneous req: with last_granted=0, req=3'b111 grants 1, then 2, then 0.

Reset
REQ-029 PRESET high SHALL immediately force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, grant=0, done=0, err=0, rdata=0, wait counter=0.
REQ-030 After reset, last_granted SHALL be 2, so requester 0 wins first.
REQ-031 Reset during SETUP/ACCESS SHALL abandon the transfer with no done pulse.

Verification
REQ-032 Single write: req=3'b001, req_write[0]=1, addr 0x10, data 0xDEADBEEF, PREADY=1 -> SETUP then ACCESS with PADDR=0x10, PWDATA=0xDEADBEEF; done=3'b001 for one cycle, err=0.
REQ-033 Read with 2 wait states: requester 1 reads 0x20, PREADY low 2 ACCESS cycles, PRDATA=0x12345678 -> ACCESS lasts 3 cycles, rdata=0x12345678, done=3'b010.
REQ-034 Round-robin: after reset hold req=3'b111 with instant PREADY -> grant order 0,1,2,0; each transfer 3 cycles.
REQ-035 Timeout: TIMEOUT=16, PREADY stuck low -> done with err=1 after 16 ACCESS cycles; next requester served afterwards.
REQ-036 PSLVERR: write with PREADY=1, PSLVERR=1 -> done pulse with err=1.
REQ-037 Reset mid-ACCESS: assert PRESET -> PSEL/PENABLE low same cycle, no done; after release, req=3'b110 grants requester 1.
